// File: rtl/oled_cmd_arbiter.sv
// Round-robin arbiter sharing one OLED driver command port between N_REQ sources,
// with a per-command lock that keeps the port for atomic multi-command sequences.
module oled_cmd_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [9*N_REQ-1:0] req_cmd,
  input  logic [N_REQ-1:0]   req_wait,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  input  logic               oled_ready,
  output logic [8:0]         oled_command,
  output logic               oled_strobe,
  output logic               oled_wait_for_busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CMD_W = 9;

  typedef enum logic [1:0] {ARB, STROBE, WAIT} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic             locked;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_onehot;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] next_ptr;
  logic [SUM_W-1:0] sum;
  logic             found;

  // While locked only the current owner may issue; scan from rr_ptr with wrap.
  always_comb begin
    cand  = locked ? (req_valid & grant) : req_valid;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      sum = SUM_W'(rr_ptr) + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      if (!found && cand[PTR_W'(sum)]) begin
        found = 1'b1;
        win   = PTR_W'(sum);
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win;
  assign next_ptr   = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ARB;
      rr_ptr             <= '0;
      locked             <= 1'b0;
      req_ack            <= '0;
      grant              <= '0;
      oled_command       <= '0;
      oled_strobe        <= 1'b0;
      oled_wait_for_busy <= 1'b0;
    end else begin
      req_ack     <= '0;
      oled_strobe <= 1'b0;
      case (state)
        ARB: begin
          if (!locked) grant <= '0;
          if (oled_ready && found) begin
            oled_command       <= req_cmd[int'(win)*CMD_W +: CMD_W];
            oled_wait_for_busy <= req_wait[win];
            oled_strobe        <= 1'b1;
            req_ack            <= win_onehot;
            grant              <= win_onehot;
            locked             <= req_lock[win];
            // A locked accept keeps the rotation point so the sequence resumes fairly.
            if (!req_lock[win]) rr_ptr <= next_ptr;
            state              <= STROBE;
          end
        end
        STROBE: state <= WAIT;
        WAIT: if (oled_ready) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// Directed bench for oled_cmd_arbiter: requester queues feed the DUT, a busy-driver
// model toggles ready, and a scoreboard of expected strobes is checked on each strobe.
module tb_oled_cmd_arbiter;

  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [9*N-1:0] req_cmd;
  logic [N-1:0]   req_wait;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           oled_ready;
  logic [8:0]     oled_command;
  logic           oled_strobe;
  logic           oled_wait_for_busy;

  always #5 clk = ~clk;

  oled_cmd_arbiter #(.N_REQ(N)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_cmd            (req_cmd),
    .req_wait           (req_wait),
    .req_lock           (req_lock),
    .req_ack            (req_ack),
    .grant              (grant),
    .oled_ready         (oled_ready),
    .oled_command       (oled_command),
    .oled_strobe        (oled_strobe),
    .oled_wait_for_busy (oled_wait_for_busy)
  );

  typedef struct {logic [8:0] cmd; logic wt; logic lk;} req_t;
  typedef struct {logic [8:0] cmd; logic wt; logic [N-1:0] who;} exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   n_strobe = 0;
  int   busy = 0;
  int   busy_len = 4;
  int   s0;
  logic ready_hold = 1'b0;
  logic [N-1:0] hold = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    req_valid[0]  = (rq0.size() > 0) && !hold[0];
    req_cmd[8:0]  = (rq0.size() > 0) ? rq0[0].cmd : 9'h0;
    req_wait[0]   = (rq0.size() > 0) ? rq0[0].wt : 1'b0;
    req_lock[0]   = (rq0.size() > 0) ? rq0[0].lk : 1'b0;
    req_valid[1]  = (rq1.size() > 0) && !hold[1];
    req_cmd[17:9] = (rq1.size() > 0) ? rq1[0].cmd : 9'h0;
    req_wait[1]   = (rq1.size() > 0) ? rq1[0].wt : 1'b0;
    req_lock[1]   = (rq1.size() > 0) ? rq1[0].lk : 1'b0;
  endtask

  // One clock: check outputs, retire acked commands, advance the driver model.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    check("ack_iff_strobe", 32'(req_ack != '0), 32'(oled_strobe));
    if (oled_strobe === 1'b1) begin
      n_strobe++;
      if (sb.size() == 0) begin
        check("strobe_expected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("strobe_cmd", 32'(oled_command), 32'(e.cmd));
        check("strobe_wait", 32'(oled_wait_for_busy), 32'(e.wt));
        check("strobe_ack", 32'(req_ack), 32'(e.who));
        check("strobe_grant", 32'(grant), 32'(e.who));
      end
    end
    if (req_ack[0] && rq0.size() > 0) void'(rq0.pop_front());
    if (req_ack[1] && rq1.size() > 0) void'(rq1.pop_front());
    present();
    if (oled_strobe === 1'b1) busy = busy_len;
    if (busy > 0) begin
      oled_ready = 1'b0;
      busy--;
    end else begin
      oled_ready = !ready_hold;
    end
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int start;
    start = n_strobe;
    for (int i = 0; i < budget && n_strobe == start; i++) cyc();
    check(tag, 32'(n_strobe != start), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) cyc();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rq0.delete();
    rq1.delete();
    hold       = '0;
    ready_hold = 1'b0;
    busy       = 0;
    busy_len   = 4;
    present();
    oled_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    oled_ready = 1'b1;
    present();

    // Reset values
    do_reset();
    cyc();
    check("rst_strobe", 32'(oled_strobe), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_cmd", 32'(oled_command), 32'd0);
    check("rst_wait", 32'(oled_wait_for_busy), 32'd0);

    // Reset mid-strobe, then quiet with no requests
    sb.push_back('{9'h155, 1'b0, 2'b01});
    rq0.push_back('{9'h155, 1'b0, 1'b0});
    present();
    wait_strobe("t1_first_strobe", 20);
    reset_n = 1'b0;
    #1;
    check("t1_async_strobe", 32'(oled_strobe), 32'd0);
    check("t1_async_ack", 32'(req_ack), 32'd0);
    check("t1_async_grant", 32'(grant), 32'd0);
    do_reset();
    s0 = n_strobe;
    repeat (100) cyc();
    check("t1_quiet", 32'(n_strobe - s0), 32'd0);

    // Single request
    sb.push_back('{9'h101, 1'b0, 2'b01});
    rq0.push_back('{9'h101, 1'b0, 1'b0});
    present();
    wait_strobe("t2_strobe", 20);
    repeat (10) cyc();

    // Round robin from a fresh pointer
    do_reset();
    rq0.push_back('{9'h041, 1'b0, 1'b0});
    rq0.push_back('{9'h041, 1'b0, 1'b0});
    rq1.push_back('{9'h142, 1'b0, 1'b0});
    rq1.push_back('{9'h142, 1'b0, 1'b0});
    sb.push_back('{9'h041, 1'b0, 2'b01});
    sb.push_back('{9'h142, 1'b0, 2'b10});
    sb.push_back('{9'h041, 1'b0, 2'b01});
    sb.push_back('{9'h142, 1'b0, 2'b10});
    present();
    drain("t3_drain", 200);
    repeat (5) cyc();

    // Locked sequence from requester 1 while requester 0 waits
    rq1.push_back('{9'h040, 1'b0, 1'b1});
    rq1.push_back('{9'h080, 1'b0, 1'b1});
    rq1.push_back('{9'h1AA, 1'b0, 1'b0});
    sb.push_back('{9'h040, 1'b0, 2'b10});
    sb.push_back('{9'h080, 1'b0, 2'b10});
    sb.push_back('{9'h1AA, 1'b0, 2'b10});
    present();
    wait_strobe("t4_first", 20);
    rq0.push_back('{9'h0F0, 1'b0, 1'b0});
    sb.push_back('{9'h0F0, 1'b0, 2'b01});
    present();
    cyc();
    check("t4_grant_locked", 32'(grant), 32'h2);
    drain("t4_drain", 200);
    repeat (5) cyc();

    // Busy driver: ready held low after a wait_for_busy command
    rq0.push_back('{9'h1C3, 1'b1, 1'b0});
    rq0.push_back('{9'h0C4, 1'b0, 1'b0});
    sb.push_back('{9'h1C3, 1'b1, 2'b01});
    sb.push_back('{9'h0C4, 1'b0, 2'b01});
    present();
    wait_strobe("t5_first", 20);
    ready_hold = 1'b1;
    s0 = n_strobe;
    repeat (50) cyc();
    check("t5_no_strobe", 32'(n_strobe - s0), 32'd0);
    check("t5_cmd_hold", 32'(oled_command), 32'h1C3);
    check("t5_wait_hold", 32'(oled_wait_for_busy), 32'd1);
    ready_hold = 1'b0;
    wait_strobe("t5_second", 30);
    repeat (5) cyc();

    // Locked owner stalls; other requester must not be served meanwhile
    rq0.push_back('{9'h011, 1'b0, 1'b1});
    sb.push_back('{9'h011, 1'b0, 2'b01});
    present();
    wait_strobe("t6_lock", 20);
    hold[0] = 1'b1;
    rq0.push_back('{9'h012, 1'b0, 1'b0});
    rq1.push_back('{9'h121, 1'b0, 1'b0});
    sb.push_back('{9'h012, 1'b0, 2'b01});
    sb.push_back('{9'h121, 1'b0, 2'b10});
    present();
    s0 = n_strobe;
    repeat (20) cyc();
    check("t6_stall", 32'(n_strobe - s0), 32'd0);
    check("t6_grant_held", 32'(grant), 32'h1);
    hold[0] = 1'b0;
    present();
    drain("t6_drain", 100);
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
